// File: rtl/if_id_decode.sv
// ============================================================================
// if_id_decode
// ----------------------------------------------------------------------------
// Instruction-decode stage of the LEGv8 core.
//
// This block has three parts:
//   * IF/ID pipeline register for the fetched instruction and its PC. Stall
//     holds the register. Flush loads a bubble.
//   * NZVC flag register. The EX stage loads it through flagWrite.
//   * Combinational decode of the registered instruction. It produces the
//     datapath controls, the register and immediate fields, and the branch
//     resolution that goes back to the fetch next-PC muxes.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   opCode[31:0]        instruction from fetch
//   pcIn[63:0]          PC of opCode
//   stall               hold the IF/ID contents
//   flush               replace the IF/ID contents with a bubble
//                       (flush takes priority over stall)
//   flagWrite           the instruction in EX writes the flags
//   aluN/aluZ/aluV/aluC flags from the EX ALU
//   rtZero              register-file read of Rt is zero (used by CBZ)
//   instrID[31:0]       registered instruction
//   pcID[63:0]          registered PC
//   validID             IF/ID holds a real instruction
//   Rd/Rn/Rm[4:0]       register fields; Rm is Rt when Reg2Loc = 0
//   Imm12, DAddr9, Shamt, CondAddr19, BrAddr26
//                       immediate fields, taken straight from instrID
//   Reg2Loc .. ShiftDir datapath controls
//   ALUSrc[1:0]         0 = register, 1 = Imm12 zero-extended,
//                       2 = DAddr9 sign-extended
//   ALUOp[2:0]          000 pass B, 010 add, 011 sub, 100 and, 110 xor
//   BrTaken, UncondBr   to the fetch next-PC logic
//   Illegal             a valid instruction that is not in the supported set
//   flags[3:0]          registered {N,Z,V,C}
// ============================================================================
module if_id_decode #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] opCode,
    input  logic [63:0] pcIn,
    input  logic        stall,
    input  logic        flush,
    input  logic        flagWrite,
    input  logic        aluN,
    input  logic        aluZ,
    input  logic        aluV,
    input  logic        aluC,
    input  logic        rtZero,
    output logic [31:0] instrID,
    output logic [63:0] pcID,
    output logic        validID,
    output logic [4:0]  Rd,
    output logic [4:0]  Rn,
    output logic [4:0]  Rm,
    output logic [11:0] Imm12,
    output logic [8:0]  DAddr9,
    output logic [5:0]  Shamt,
    output logic [18:0] CondAddr19,
    output logic [25:0] BrAddr26,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        SetFlags,
    output logic        ShiftEn,
    output logic        ShiftDir,
    output logic [1:0]  ALUSrc,
    output logic [2:0]  ALUOp,
    output logic        BrTaken,
    output logic        UncondBr,
    output logic        Illegal,
    output logic [3:0]  flags
);

    // ------------------------------------------------------------------------
    // Opcode patterns
    // ------------------------------------------------------------------------
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;    // [31:22]
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;   // [31:21]
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [5:0]  OPC_B    = 6'b000101;         // [31:26]
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;       // [31:24]
    localparam logic [7:0]  OPC_BCND = 8'b01010100;       // [31:24]
    localparam logic [4:0]  COND_LT  = 5'b01011;          // [4:0]

    // ALU source and operation encodings
    localparam logic [1:0] SRC_REG   = 2'd0;
    localparam logic [1:0] SRC_IMM12 = 2'd1;
    localparam logic [1:0] SRC_DADDR = 2'd2;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_ADDI,
        OP_ADDS,
        OP_SUBS,
        OP_AND,
        OP_EOR,
        OP_LSL,
        OP_LSR,
        OP_LDUR,
        OP_STUR,
        OP_B,
        OP_CBZ,
        OP_BLT
    } op_e;

    typedef struct packed {
        logic       reg2loc;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       set_flags;
        logic       shift_en;
        logic       shift_dir;
        logic [1:0] alu_src;
        logic [2:0] alu_op;
        logic       uncond_br;
        logic       br_taken;
    } ctrl_t;

    op_e   op_cls;
    ctrl_t ctrl;
    logic  n_eff;
    logic  v_eff;

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples its inputs as they were before the edge, and the
    // order of the statements does not matter.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            instrID <= NOP_INSTR;
            pcID    <= '0;
            validID <= 1'b0;
        end else if (!stall) begin
            instrID <= opCode;
            pcID    <= pcIn;
            validID <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // NZVC flag register. It is independent of stall and flush, so an EX
    // instruction can still retire its flags while decode is frozen.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (flagWrite) begin
            flags <= {aluN, aluZ, aluV, aluC};
        end
    end

    // Forward the EX flags when they are written in this cycle. This lets a
    // B.LT directly behind a flag-setting instruction see the new values.
    assign n_eff = flagWrite ? aluN : flags[3];
    assign v_eff = flagWrite ? aluV : flags[1];

    // ------------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------------
    // NOTE: every signal driven in a combinational block gets a default
    // value first. Then no path leaves it unassigned, and no latch is inferred.
    always_comb begin
        op_cls = OP_NONE;
        if (instrID[31:22] == OPC_ADDI) begin
            op_cls = OP_ADDI;
        end else if (instrID[31:26] == OPC_B) begin
            op_cls = OP_B;
        end else if (instrID[31:24] == OPC_CBZ) begin
            op_cls = OP_CBZ;
        end else if (instrID[31:24] == OPC_BCND) begin
            // Only the LT condition is supported; other conditions stay
            // unmatched and are reported as Illegal.
            if (instrID[4:0] == COND_LT) begin
                op_cls = OP_BLT;
            end
        end else begin
            case (instrID[31:21])
                OPC_ADDS: op_cls = OP_ADDS;
                OPC_SUBS: op_cls = OP_SUBS;
                OPC_AND:  op_cls = OP_AND;
                OPC_EOR:  op_cls = OP_EOR;
                OPC_LSL:  op_cls = OP_LSL;
                OPC_LSR:  op_cls = OP_LSR;
                OPC_LDUR: op_cls = OP_LDUR;
                OPC_STUR: op_cls = OP_STUR;
                default:  op_cls = OP_NONE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control decode. A bubble or an unmatched opcode keeps every control at
    // zero, so no state changes and fetch continues sequentially.
    // ------------------------------------------------------------------------
    always_comb begin
        ctrl = '0;
        if (validID) begin
            case (op_cls)
                OP_ADDI: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = SRC_IMM12;
                    ctrl.alu_op    = ALU_ADD;
                end
                OP_ADDS: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg2loc   = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.set_flags = 1'b1;
                end
                OP_SUBS: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg2loc   = 1'b1;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.set_flags = 1'b1;
                end
                OP_AND: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg2loc   = 1'b1;
                    ctrl.alu_op    = ALU_AND;
                end
                OP_EOR: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg2loc   = 1'b1;
                    ctrl.alu_op    = ALU_XOR;
                end
                OP_LSL: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.shift_en  = 1'b1;
                    ctrl.shift_dir = 1'b0;
                end
                OP_LSR: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.shift_en  = 1'b1;
                    ctrl.shift_dir = 1'b1;
                end
                OP_LDUR: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.alu_src    = SRC_DADDR;
                    ctrl.alu_op     = ALU_ADD;
                end
                OP_STUR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.reg2loc   = 1'b0;
                    ctrl.alu_src   = SRC_DADDR;
                    ctrl.alu_op    = ALU_ADD;
                end
                OP_B: begin
                    ctrl.uncond_br = 1'b1;
                    ctrl.br_taken  = 1'b1;
                end
                OP_CBZ: begin
                    ctrl.reg2loc   = 1'b0;
                    ctrl.alu_op    = ALU_PASSB;
                    ctrl.br_taken  = rtZero;
                end
                OP_BLT: begin
                    ctrl.br_taken  = n_eff ^ v_eff;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

    assign Illegal = validID && (op_cls == OP_NONE);

    // ------------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------------
    assign Reg2Loc  = ctrl.reg2loc;
    assign RegWrite = ctrl.reg_write;
    assign MemWrite = ctrl.mem_write;
    assign MemRead  = ctrl.mem_read;
    assign MemToReg = ctrl.mem_to_reg;
    assign SetFlags = ctrl.set_flags;
    assign ShiftEn  = ctrl.shift_en;
    assign ShiftDir = ctrl.shift_dir;
    assign ALUSrc   = ctrl.alu_src;
    assign ALUOp    = ctrl.alu_op;
    assign UncondBr = ctrl.uncond_br;
    assign BrTaken  = ctrl.br_taken;

    // ------------------------------------------------------------------------
    // Field outputs. They are driven from instrID even for bubbles. Only the
    // second read port selects between Rm (R-format) and Rt (loads, stores,
    // CBZ).
    // ------------------------------------------------------------------------
    assign Rd         = instrID[4:0];
    assign Rn         = instrID[9:5];
    assign Rm         = ctrl.reg2loc ? instrID[20:16] : instrID[4:0];
    assign Imm12      = instrID[21:10];
    assign DAddr9     = instrID[20:12];
    assign Shamt      = instrID[15:10];
    assign CondAddr19 = instrID[23:5];
    assign BrAddr26   = instrID[25:0];

endmodule

// File: doc/if_id_decode.md
# if_id_decode

Instruction-decode stage for the LEGv8 core. It registers the 32-bit `opCode` and PC from the fetch block into an IF/ID pipeline register, with stall and flush. From the registered instruction it combinationally decodes the datapath controls, register fields and branch fields. It keeps the NZVC flag register and resolves `BrTaken` and `UncondBr`, which feed back to the fetch block's next-PC muxes.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h0000_0000: instruction value loaded on reset and flush.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `opCode`  in  32  instruction from fetch
- `pcIn`  in  64  PC of `opCode`
- `stall`  in  1  hold IF/ID contents
- `flush`  in  1  replace IF/ID contents with a bubble
- `flagWrite`  in  1  the EX instruction sets flags
- `aluN`, `aluZ`, `aluV`, `aluC`  in  1 each  flags from the EX ALU
- `rtZero`  in  1  register-file read of Rt equals zero (used by CBZ)
- `instrID`  out  32  registered instruction
- `pcID`  out  64  registered PC
- `validID`  out  1  IF/ID holds a real instruction
- `Rd`, `Rn`, `Rm`  out  5 each  register fields; `Rm` is Rt when `Reg2Loc`=0
- `Imm12`  out  12  instruction bits [21:10]
- `DAddr9`  out  9  instruction bits [20:12]
- `Shamt`  out  6  instruction bits [15:10]
- `CondAddr19`  out  19  instruction bits [23:5]
- `BrAddr26`  out  26  instruction bits [25:0]
- `Reg2Loc`, `RegWrite`, `MemWrite`, `MemRead`, `MemToReg`, `SetFlags`, `ShiftEn`, `ShiftDir`  out  1 each  datapath controls
- `ALUSrc`  out  2  0 = register, 1 = Imm12 zero-extended, 2 = DAddr9 sign-extended
- `ALUOp`  out  3  000 = pass B, 010 = add, 011 = subtract, 100 = and, 110 = xor
- `BrTaken`, `UncondBr`  out  1 each  to the fetch next-PC logic
- `Illegal`  out  1  the valid instruction is not in the supported set
- `flags`  out  4  registered {N,Z,V,C}

## Operation
- IF/ID register update on each clock edge, in priority order:
  - reset low: `instrID`=`NOP_INSTR`, `pcID`=0, `validID`=0.
  - else `flush`: same values as reset. `flush` wins over `stall`.
  - else `stall`: hold all contents.
  - else: load `opCode` and `pcIn`, set `validID`=1.
- Flag register:
  - reset low: 0.
  - else `flagWrite`: load {aluN,aluZ,aluV,aluC}.
  - `flush` and `stall` do not affect it.
- Decode is combinational from `instrID`:
  - ADDI, [31:22]=1001000100: RegWrite, ALUSrc=1, ALUOp=add.
  - ADDS, [31:21]=10101011000: RegWrite, Reg2Loc=1, ALUOp=add, SetFlags.
  - SUBS, 11101011000: as ADDS with ALUOp=subtract.
  - AND, 10001010000: RegWrite, Reg2Loc=1, ALUOp=and.
  - EOR, 11001010000: RegWrite, Reg2Loc=1, ALUOp=xor.
  - LSL, 11010011011: RegWrite, ShiftEn, ShiftDir=0.
  - LSR, 11010011010: RegWrite, ShiftEn, ShiftDir=1.
  - LDUR, 11111000010: RegWrite, MemRead, MemToReg, ALUSrc=2, ALUOp=add.
  - STUR, 11111000000: MemWrite, Reg2Loc=0, ALUSrc=2, ALUOp=add.
  - B, [31:26]=000101: UncondBr=1, BrTaken=1.
  - CBZ, [31:24]=10110100: Reg2Loc=0, ALUOp=pass B, UncondBr=0, BrTaken=`rtZero`.
  - B.LT, [31:24]=01010100 with cond [4:0]=01011: UncondBr=0, BrTaken=(N xor V) of the effective flags. Any other cond value is Illegal.
- Effective flags for B.LT: the incoming ALU flags when `flagWrite` is high in the same cycle (forwarding), otherwise the registered flags.
- When `validID`=0, or when the opcode is unmatched, all write enables, SetFlags, BrTaken and UncondBr are 0.
- `Illegal`=1 only when `validID`=1 and the opcode is unmatched.
- Field outputs are always driven from `instrID`, regardless of validity.

## Timing
- Latency from fetch to decode is 1 cycle: `opCode` presented in cycle n appears on `instrID` and the controls in cycle n+1.
- `BrTaken` and `UncondBr` are combinational within the ID cycle. The fetch block uses `pcID` together with `CondAddr19` or `BrAddr26` to form the target.
- Branch-taken recovery: the controller asserts `flush` in the ID cycle of a taken branch. The next edge squashes the wrong-path fetch.
- Stall for N cycles: `instrID` and the controls stay constant for N cycles. Flags may still update during the stall.
- Reset low mid-stream: all outputs reach their reset values on the next edge (controls 0, `flags`=0), regardless of `stall` or `flush`.

## Test plan
- Reset low for 2 cycles, then high with `opCode`=0x910017E1 (ADDI X1,X31,#5) -> next cycle: `validID`=1, Rd=1, Rn=31, Imm12=5, RegWrite=1, ALUSrc=1, ALUOp=010.
- `opCode`=0x14000003 (B #3) -> ID cycle: BrTaken=1, UncondBr=1, BrAddr26=3. Assert `flush` -> next cycle: `validID`=0, all controls 0.
- `opCode`=0xB4FFFFC2 (CBZ X2,#-2) with `rtZero`=1, then repeat with `rtZero`=0 -> BrTaken=1 then 0; CondAddr19=0x7FFFE, Rm=2, Reg2Loc=0.
- Case A: `flagWrite`=1 with N=1, V=0, while `opCode`=0x5400008B (B.LT #4). Case B: same B.LT in ID with `flagWrite`=1, N=0, V=0, against registered N=1 -> Case A: BrTaken=1 when B.LT is in ID. Case B: forwarded flags give BrTaken=0, and `flags` updates to 0000.
- `opCode`=0xF8008083 (STUR X3,[X4,#8]) with `stall`=1 for 3 cycles while `opCode` changes -> `instrID` holds 0xF8008083; MemWrite=1, DAddr9=8, Rn=4, Rm=3, RegWrite=0.
- `opCode`=0xFFFFFFFF, then `stall` and `flush` asserted together -> first `Illegal`=1 and all enables 0; after the edge with both asserted, `validID`=0.
